// File: rtl/mem_test_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_test_seq_if
// Purpose  : Bus between the memory test sequencer and the memory pair under
//            test. One write port (strobe, address, data) fans out to both
//            memories. Each memory returns its own combinational read of the
//            shared address.
// Signals  : write_enable  write strobe; memories write on posedge clk
//            address       ADDR_W-bit word address
//            wdata         DATA_W-bit write data
//            bm_data       behavioural memory read data
//            sm_data       structural memory read data
// Modports : master = sequencer side, slave = memory side
// Revision : 1.0  initial release
// ============================================================================
interface mem_test_seq_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
);
  logic              write_enable;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] bm_data;
  logic [DATA_W-1:0] sm_data;

  modport master (
    output write_enable,
    output address,
    output wdata,
    input  bm_data,
    input  sm_data
  );

  modport slave (
    input  write_enable,
    input  address,
    input  wdata,
    output bm_data,
    output sm_data
  );
endinterface
`default_nettype wire

// File: rtl/mem_test_seq.sv
`default_nettype none
// ============================================================================
// Module   : mem_test_seq
// Purpose  : Fills every word of a memory pair with BASE ^ address, then reads
//            each word back. A word is bad if the two read ports disagree or
//            if the data differs from the pattern. Reports pass/fail, the
//            number of bad words and the first bad address.
// Ports    : clk             rising-edge clock
//            rst_n           asynchronous active-low reset
//            start           begin a run (honoured only in IDLE and DONE)
//            bus             memory bus (master modport)
//            busy            high while writing or reading
//            done            high once a run has finished
//            pass            1 = no bad words (meaningful only with done)
//            err_count       number of bad words, 0..2**ADDR_W
//            first_err_addr  address of the first bad word, 0 if none
// Revision : 1.0  initial release
// ============================================================================
module mem_test_seq #(
  parameter int              ADDR_W = 3,
  parameter int              DATA_W = 32,
  parameter logic [DATA_W-1:0] BASE = 32'hC000_0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  mem_test_seq_if.master    bus,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [ADDR_W:0]   err_q, err_nxt;
  logic [ADDR_W-1:0] first_q, first_nxt;
  logic              seen_q, seen_nxt;   // a mismatch already recorded this run
  logic              pass_q, pass_nxt;

  logic [DATA_W-1:0] expected;
  logic              mismatch;

  assign expected = BASE ^ {{(DATA_W-ADDR_W){1'b0}}, addr_q};

  // Both failure causes collapse into one flag so a word is counted once.
  assign mismatch = (bus.bm_data != bus.sm_data) || (bus.bm_data != expected);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      err_q   <= '0;
      first_q <= '0;
      seen_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      addr_q  <= addr_nxt;
      err_q   <= err_nxt;
      first_q <= first_nxt;
      seen_q  <= seen_nxt;
      pass_q  <= pass_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    err_nxt   = err_q;
    first_nxt = first_q;
    seen_nxt  = seen_q;
    pass_nxt  = pass_q;

    case (state)
      IDLE, DONE: begin
        addr_nxt = '0;
        if (start) begin
          state_nxt = WRITE;
          err_nxt   = '0;
          first_nxt = '0;
          seen_nxt  = 1'b0;
          pass_nxt  = 1'b0;
        end
      end

      WRITE: begin
        if (addr_q == LAST_ADDR) begin
          state_nxt = READ;
          addr_nxt  = '0;
        end else begin
          addr_nxt = addr_q + 1'b1;
        end
      end

      READ: begin
        if (mismatch) begin
          err_nxt = err_q + 1'b1;
          if (!seen_q) begin
            first_nxt = addr_q;
            seen_nxt  = 1'b1;
          end
        end
        if (addr_q == LAST_ADDR) begin
          // The final word's compare is folded in through err_nxt.
          state_nxt = DONE;
          addr_nxt  = '0;
          pass_nxt  = (err_nxt == '0);
        end else begin
          addr_nxt = addr_q + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        addr_nxt  = '0;
      end
    endcase
  end

  assign bus.write_enable = (state == WRITE);
  assign bus.address      = addr_q;
  assign bus.wdata        = (state == WRITE) ? expected : '0;

  assign busy           = (state == WRITE) || (state == READ);
  assign done           = (state == DONE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_test_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_test_seq
// Purpose  : Scoreboard bench for mem_test_seq. Each run pushes its expected
//            write transactions and its expected result into queues; a monitor
//            pops and compares whenever a write strobe or a done edge appears.
//            The memory pair is modelled here, with fault injection.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_test_seq;
  localparam int          ADDR_W = 3;
  localparam int          DATA_W = 32;
  localparam logic [31:0] BASE   = 32'hC000_0001;

  typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;
  typedef struct { logic p; logic [ADDR_W:0] e; logic [ADDR_W-1:0] f; } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, pass;
  logic [ADDR_W:0]   err_count;
  logic [ADDR_W-1:0] first_err_addr;

  int n_checks = 0;
  int n_pass   = 0;

  wr_t  exp_wr[$];
  res_t exp_res[$];

  logic [DATA_W-1:0] bm_mem [2**ADDR_W];
  logic [DATA_W-1:0] sm_mem [2**ADDR_W];
  logic fault5 = 1'b0;  // structural port returns bm^1 at address 5
  logic stuck  = 1'b0;  // both ports read 0

  mem_test_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_test_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE(BASE)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .bus            (bus.master),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.write_enable) begin
      bm_mem[bus.address] <= bus.wdata;
      sm_mem[bus.address] <= bus.wdata;
    end
  end

  assign bus.bm_data = stuck ? '0 : bm_mem[bus.address];
  assign bus.sm_data = stuck ? '0 :
                       (fault5 && bus.address == 3'd5) ? (bm_mem[bus.address] ^ 32'd1) :
                       sm_mem[bus.address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Expected writes: addr 0..7 with C0000001, C0000000, C0000003, C0000002,
  // C0000005, C0000004, C0000007, C0000006.
  task automatic push_run(input logic p, input logic [ADDR_W:0] e, input logic [ADDR_W-1:0] f);
    logic [31:0] pat [8];
    pat = '{32'hC000_0001, 32'hC000_0000, 32'hC000_0003, 32'hC000_0002,
            32'hC000_0005, 32'hC000_0004, 32'hC000_0007, 32'hC000_0006};
    for (int i = 0; i < 8; i++) exp_wr.push_back('{a: 3'(i), d: pat[i]});
    exp_res.push_back('{p: p, e: e, f: f});
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: writes are checked against the write queue; a rising done pops
  // a result and also checks that exactly 16 busy cycles preceded it.
  int   busy_run  = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      if (bus.write_enable) begin
        if (exp_wr.size() == 0) check("unexpected_write", 32'd1, 32'd0);
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("wr_addr", 32'(bus.address), 32'(w.a));
          check("wr_data", bus.wdata, w.d);
        end
      end
      if (busy) busy_run++;
      if (!done) check("pass_low_outside_done", 32'(pass), 32'd0);
      if (done && !prev_done) begin
        check("busy_cycles", busy_run, 16);
        busy_run = 0;
        if (exp_res.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else begin
          res_t r;
          r = exp_res.pop_front();
          check("pass", 32'(pass), 32'(r.p));
          check("err_count", 32'(err_count), 32'(r.e));
          check("first_err_addr", 32'(first_err_addr), 32'(r.f));
        end
      end
      prev_done = done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_err", 32'(err_count), 0);
    check("rst_first", 32'(first_err_addr), 0);
    check("rst_we", 32'(bus.write_enable), 0);
    check("rst_addr", 32'(bus.address), 0);
    check("rst_wdata", bus.wdata, 0);
    rst_n = 1'b1;

    // 1: good memories
    push_run(1'b1, 4'd0, 3'd0);
    pulse_start();
    wait_done();

    // 2: structural port wrong at address 5
    fault5 = 1'b1;
    push_run(1'b0, 4'd1, 3'd5);
    pulse_start();
    wait_done();
    fault5 = 1'b0;

    // 3: both ports stuck at 0
    stuck = 1'b1;
    push_run(1'b0, 4'd8, 3'd0);
    pulse_start();
    wait_done();
    stuck = 1'b0;

    // 5: start during WRITE ignored; err_count cleared from 8 on the new run
    push_run(1'b1, 4'd0, 3'd0);
    pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    push_run(1'b1, 4'd0, 3'd0);
    pulse_start();
    wait_done();

    // 4: reset during READ at address 3
    push_run(1'b1, 4'd0, 3'd0);
    pulse_start();
    begin
      bit hit = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (busy && !bus.write_enable && bus.address == 3'd3) begin hit = 1; break; end
      end
      check("reached_read3", 32'(hit), 1);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_we", 32'(bus.write_enable), 0);
    check("midrst_addr", 32'(bus.address), 0);
    check("midrst_err", 32'(err_count), 0);
    exp_res.delete();
    exp_wr.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_run(1'b1, 4'd0, 3'd0);
    pulse_start();
    wait_done();

    // 6: start held high -> back-to-back runs, done high for one cycle
    push_run(1'b1, 4'd0, 3'd0);
    push_run(1'b1, 4'd0, 3'd0);
    push_run(1'b1, 4'd0, 3'd0);
    @(negedge clk);
    start = 1'b1;
    for (int r = 0; r < 2; r++) begin
      wait_done();
      @(negedge clk);
      check("b2b_done_1cycle", 32'(done), 0);
      check("b2b_busy_again", 32'(busy), 1);
    end
    wait_done();
    start = 1'b0;
    @(negedge clk);
    check("done_holds", 32'(done), 1);
    check("pass_holds", 32'(pass), 1);
    check("wr_queue_empty", exp_wr.size(), 0);
    check("res_queue_empty", exp_res.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
